// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU: command encoding, arbiter states, default width.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [3:0] {
    OP_AND    = 4'd0,
    OP_XOR    = 4'd1,
    OP_OR     = 4'd2,
    OP_LSL    = 4'd3,
    OP_LSR    = 4'd4,
    OP_ADD    = 4'd5,
    OP_SUB    = 4'd6,
    OP_PASS_A = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Upper half of the command space carries no operation.
  function automatic logic cmd_illegal(input logic [3:0] cmd);
    return cmd[3];
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, single-bit shifts through a carry, wrapping add/sub.
module alu
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  alu_op_e        op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cin,
  output logic [W-1:0]   rslt,
  output logic           cout
);

  always_comb begin
    rslt = '0;
    cout = 1'b0;
    case (op)
      OP_AND:    rslt = a & b;
      OP_XOR:    rslt = a ^ b;
      OP_OR:     rslt = a | b;
      OP_LSL:    {cout, rslt} = {a, cin};
      OP_LSR:    {rslt, cout} = {cin, a};
      OP_ADD:    rslt = a + b;
      OP_SUB:    rslt = a - b;
      OP_PASS_A: rslt = a;
      default:   rslt = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU (grant -> exec -> response).
// Optional ALU_ARB_LOCK_EN adds req_lock so a requester can retain priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W    = ALU_W,
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][3:0]     req_cmd,
  input  logic [NREQ-1:0][W-1:0]   req_a,
  input  logic [NREQ-1:0][W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_cin,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]          req_lock,
`endif
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [W-1:0]             rsp_rslt,
  output logic                     rsp_cout,
  output logic                     rsp_err
);

  arb_state_e      state_q, state_d;
  logic            prio_q, prio_d;
  logic            gnt_q, gnt_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d;
  logic            rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_rslt_q, rsp_rslt_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] ready_raw;
  logic            sel;
  logic            lock_hit;
  logic [W-1:0]    alu_rslt;
  logic            alu_cout;

  alu #(.W(W)) u_alu (
    .op   (alu_op_e'(cmd_q)),
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .rslt (alu_rslt),
    .cout (alu_cout)
  );

`ifdef ALU_ARB_LOCK_EN
  assign lock_hit = req_lock[gnt_q];
`else
  assign lock_hit = 1'b0;
`endif

  assign sel = req_valid[prio_q] ? prio_q : ~prio_q;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    rsp_id_d   = rsp_id_q;
    rsp_rslt_d = rsp_rslt_q;
    rsp_cout_d = rsp_cout_q;
    rsp_err_d  = rsp_err_q;
    ready_raw  = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_raw[sel] = 1'b1;
          gnt_d          = sel;
          cmd_d          = req_cmd[sel];
          a_d            = req_a[sel];
          b_d            = req_b[sel];
          cin_d          = req_cin[sel];
          state_d        = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d  = gnt_q;
        rsp_err_d = cmd_illegal(cmd_q);
        // Illegal commands must not leak whatever the ALU happens to produce.
        rsp_rslt_d = rsp_err_d ? '0 : alu_rslt;
        rsp_cout_d = rsp_err_d ? 1'b0 : alu_cout;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          prio_d  = lock_hit ? gnt_q : ~gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational from IDLE; mask it so reset forces it low immediately.
  assign req_ready = ready_raw & {NREQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      gnt_q      <= 1'b0;
      cmd_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_rslt_q <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_q      <= gnt_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      rsp_id_q   <= rsp_id_d;
      rsp_rslt_q <= rsp_rslt_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_rslt  = rsp_rslt_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, round-robin order, illegal commands, stall, reset abort.
// Lock-priority vector is compiled in only with ALU_ARB_LOCK_EN.
module tb_alu_arbiter;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][3:0] req_cmd;
  logic [1:0][7:0] req_a;
  logic [1:0][7:0] req_b;
  logic [1:0]      req_cin;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]      req_lock;
`endif
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [7:0]      rsp_rslt;
  logic            rsp_cout;
  logic            rsp_err;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.W(8), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_rslt  (rsp_rslt),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic arm(input int id, input logic [3:0] cmd, input logic [7:0] a,
                     input logic [7:0] b, input logic cin);
    req_cmd[id]   = cmd;
    req_a[id]     = a;
    req_b[id]     = b;
    req_cin[id]   = cin;
    req_valid[id] = 1'b1;
  endtask

  // Expects the next grant to go to requester id; walks it through to completion.
  task automatic run(input int id, input logic [7:0] er, input logic ec, input logic ee,
                     input int stall);
    int n;
    logic [1:0] exp_rdy;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == 2'b00) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    exp_rdy = 2'b01 << id;
    chk("grant_sel", req_ready, exp_rdy);
    chk("rspv_N", rsp_valid, 0);
    @(negedge clk);
    req_valid[id] = 1'b0;
    chk("exec_ready", req_ready, 0);
    chk("rspv_N1", rsp_valid, 0);
    @(negedge clk);
    chk("rspv_N2", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_rslt", rsp_rslt, er);
    chk("rsp_cout", rsp_cout, ec);
    chk("rsp_err", rsp_err, ee);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rslt", rsp_rslt, er);
      chk("stall_id", rsp_id, id);
      chk("stall_ready", req_ready, 0);
    end
    $display("op id=%0d rslt=%02h cout=%0b err=%0b exp_rslt=%02h", rsp_id, rsp_rslt,
             rsp_cout, rsp_err, er);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rspv_done", rsp_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_cmd   = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = 2'b00;
`endif
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_rslt", rsp_rslt, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_err", rsp_err, 0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD on requester 0.
    arm(0, 4'd5, 8'hAA, 8'h55, 1'b0);
    run(0, 8'hFF, 1'b0, 1'b0, 0);

    // Requester 0 served last, so requester 1 wins a tie.
    arm(0, 4'd2, 8'hF0, 8'h0F, 1'b0);
    arm(1, 4'd1, 8'hF0, 8'h3C, 1'b0);
    run(1, 8'hCC, 1'b0, 1'b0, 0);
    run(0, 8'hFF, 1'b0, 1'b0, 0);

    // Fresh reset: requester 0 has priority on a tie.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    arm(0, 4'd0, 8'hAA, 8'h55, 1'b0);
    arm(1, 4'd6, 8'hAA, 8'h55, 1'b0);
    run(0, 8'h00, 1'b0, 1'b0, 0);
    run(1, 8'h55, 1'b0, 1'b0, 0);

    // Illegal command.
    arm(1, 4'd9, 8'hAA, 8'h55, 1'b1);
    run(1, 8'h00, 1'b0, 1'b1, 0);

    // Response stalled 5 cycles with the other requester waiting.
    arm(0, 4'd1, 8'h12, 8'h34, 1'b0);
    arm(1, 4'd5, 8'h10, 8'h20, 1'b0);
    run(0, 8'h26, 1'b0, 1'b0, 5);
    run(1, 8'h30, 1'b0, 1'b0, 0);

    // Shifts, wraparound and pass-through.
    arm(0, 4'd3, 8'h81, 8'h00, 1'b1);
    run(0, 8'h03, 1'b1, 1'b0, 0);
    arm(1, 4'd4, 8'h81, 8'h00, 1'b0);
    run(1, 8'h40, 1'b1, 1'b0, 0);
    arm(0, 4'd4, 8'h02, 8'h00, 1'b1);
    run(0, 8'h81, 1'b0, 1'b0, 0);
    arm(1, 4'd6, 8'h00, 8'h01, 1'b0);
    run(1, 8'hFF, 1'b0, 1'b0, 0);
    arm(0, 4'd5, 8'hFF, 8'h01, 1'b1);
    run(0, 8'h00, 1'b0, 1'b0, 0);
    arm(0, 4'd15, 8'h33, 8'h44, 1'b1);
    run(0, 8'h00, 1'b0, 1'b1, 0);
    arm(1, 4'd7, 8'h5A, 8'hFF, 1'b1);
    run(1, 8'h5A, 1'b0, 1'b0, 0);

`ifdef ALU_ARB_LOCK_EN
    // Requester 0 holds lock: it keeps priority across consecutive ops.
    req_lock = 2'b01;
    arm(0, 4'd2, 8'h01, 8'h02, 1'b0);
    arm(1, 4'd0, 8'hFF, 8'h0F, 1'b0);
    run(0, 8'h03, 1'b0, 1'b0, 0);
    arm(0, 4'd5, 8'h01, 8'h02, 1'b0);
    run(0, 8'h03, 1'b0, 1'b0, 0);
    req_lock = 2'b00;
    run(1, 8'h0F, 1'b0, 1'b0, 0);
`endif

    // Reset while in EXEC abandons the op (rsp_rslt currently holds 0x5A).
    arm(0, 4'd5, 8'h0F, 8'h01, 1'b0);
    #1;
    begin
      int n;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("abort_grant", req_ready, 2'b01);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rspv", rsp_valid, 0);
    chk("abort_rslt", rsp_rslt, 0);
    chk("abort_err", rsp_err, 0);
    chk("abort_ready", req_ready, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    chk("abort_rslt_hold", rsp_rslt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
